// File: rtl/channel_capture.sv
// channel_capture: per-channel acquisition front end.
// Synchronizes one probe input, run-length encodes its edges into 32-bit
// event words and queues them in a DEPTH-word FIFO for the transfer stage.
// Optional build macro: CHANNEL_CAPTURE_GLITCH_FILTER_EN adds a 3-sample
// stability stage after the synchronizer.
module channel_capture #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 27
) (
    input  logic        i_clk,
    input  logic        _rst,
    input  logic        sig_in,
    input  logic        enable,
    input  logic        read,
    output logic [31:0] data_out,
    output logic        available,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Synchronizer and edge detection
    logic r_sync1;
    logic r_sync2;
    logic r_s_prev;
    logic w_s;
    logic w_edge;

    // Two-flop synchronizer for the asynchronous probe
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CHANNEL_CAPTURE_GLITCH_FILTER_EN
    logic r_hist1;
    logic r_hist2;
    logic r_filt;

    // Stability stage: two history flops plus the held filtered level
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_filt  <= w_s;
        end
    end

    // Follow the synchronized input only once three consecutive samples agree
    assign w_s = ((r_sync2 == r_hist1) && (r_hist1 == r_hist2)) ? r_sync2 : r_filt;
`else
    assign w_s = r_sync2;
`endif

    // Previous level of the (possibly filtered) signal for edge detection
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_s_prev <= 1'b0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    assign w_edge = w_s ^ r_s_prev;

    // Read strobe edge detection
    logic r_read_prev;
    logic w_pop;

    // Remember last read level so a held read pops only once
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_read_prev <= 1'b0;
        end else begin
            r_read_prev <= read;
        end
    end

    // FIFO state
    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [31:0]    r_dout;
    logic           r_overflow;

    assign w_pop = read & ~r_read_prev & (r_count != '0);

    // Encoder FSM state
    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_next;
    logic                  w_push;
    logic [31:0]           w_push_word;
    logic                  w_ovf_clr;

    // Encoder state and delta counter registers
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, delta counter and event word generation
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_push       = 1'b0;
        w_push_word  = '0;
        w_ovf_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                    w_push       = 1'b1;
                    w_push_word  = {3'b000, 1'b0, w_s, {CNT_WIDTH{1'b0}}};
                    w_cnt_next   = CNT_WIDTH'(1);
                    w_ovf_clr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_edge) begin
                    w_push      = 1'b1;
                    w_push_word = {3'b000, 1'b0, w_s, r_cnt};
                    w_cnt_next  = CNT_WIDTH'(1);
                end else if (r_cnt == CNT_MAX) begin
                    // Saturation marker keeps the DELTA sum equal to elapsed cycles
                    w_push      = 1'b1;
                    w_push_word = {3'b000, 1'b1, w_s, CNT_MAX};
                    w_cnt_next  = CNT_WIDTH'(1);
                end else begin
                    w_cnt_next  = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO control: a pop frees the slot for a same-cycle push when full
    logic           w_full;
    logic           w_wr;
    logic           w_drop;
    logic [AW:0]    w_count_next;
    logic [AW-1:0]  w_rd_ptr_next;

    assign w_full        = (r_count == (AW+1)'(DEPTH));
    assign w_wr          = w_push & (~w_full | w_pop);
    assign w_drop        = w_push & w_full & ~w_pop;
    assign w_count_next  = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // Pointer, occupancy and sticky overflow registers
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage array write port
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    // Registered head read; a push into an empty-after-pop FIFO is forwarded
    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            r_dout <= '0;
        end else if (w_count_next != '0) begin
            if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
                r_dout <= w_push_word;
            end else begin
                r_dout <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign data_out  = r_dout;
    assign available = (r_count != '0);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_channel_capture.sv
// tb_channel_capture: directed and randomized checks of channel_capture
// against a cycle-count based model of the event word stream.
module tb_channel_capture;

    localparam int DEPTH = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sig_in  = 1'b0;
    logic        enable  = 1'b0;
    logic        read    = 1'b0;
    logic [31:0] data_out;
    logic        available;
    logic        overflow;

    always #5 clk = ~clk;

    channel_capture #(
        .DEPTH(DEPTH),
        .CNT_WIDTH(27)
    ) dut (
        .i_clk(clk),
        ._rst(rst_n),
        .sig_in(sig_in),
        .enable(enable),
        .read(read),
        .data_out(data_out),
        .available(available),
        .overflow(overflow)
    );

    // Reference model: queue of expected words, probe delayed two samples,
    // DELTA taken as the cycle distance to the previous recorded event.
    logic [31:0] m_q[$];
    bit          m_run;
    bit          m_ovf;
    bit          m_d1;
    bit          m_d2;
    bit          m_sprev;
    bit          m_rdprev;
    int          m_cyc  = 0;
    int          m_last = 0;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          s_now;
        bit          pop;
        bit          push;
        logic [31:0] w;
        m_cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_run    = 0;
            m_ovf    = 0;
            m_d1     = 0;
            m_d2     = 0;
            m_sprev  = 0;
            m_rdprev = 0;
            return;
        end
        s_now = m_d2;
        pop   = read && !m_rdprev && (m_q.size() > 0);
        push  = 0;
        w     = '0;
        if (!m_run) begin
            if (enable) begin
                m_run  = 1;
                m_ovf  = 0;
                push   = 1;
                w      = {4'b0000, s_now, 27'd0};
                m_last = m_cyc;
            end
        end else if (!enable) begin
            m_run = 0;
        end else if (s_now != m_sprev) begin
            push   = 1;
            w      = {4'b0000, s_now, 27'(m_cyc - m_last)};
            m_last = m_cyc;
        end
        if (push && (m_q.size() == DEPTH) && !pop) begin
            m_ovf = 1;
            push  = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(w);
        m_sprev  = s_now;
        m_d2     = m_d1;
        m_d1     = sig_in;
        m_rdprev = read;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("available", {31'b0, available}, {31'b0, m_q.size() != 0});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (m_q.size() != 0) chk("data_out", data_out, m_q[0]);
    endtask

    task automatic pulse();
        read = 1'b1;
        cyc();
        read = 1'b0;
        cyc();
    endtask

    task automatic drain(output int cnt);
        cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (!available) break;
            pulse();
            cnt++;
        end
    endtask

    task automatic toggle_edge();
        sig_in = ~sig_in;
        cyc();
        cyc();
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_dout", data_out, 32'h0);
        chk("rst_avail", {31'b0, available}, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);

        // Start word with probe high
        rst_n  = 1'b1;
        sig_in = 1'b1;
        repeat (3) cyc();
        enable = 1'b1;
        cyc();
        chk("start_word", data_out, 32'h0800_0000);
        chk("start_avail", {31'b0, available}, 32'h1);
        enable = 1'b0;
        cyc();
        pulse();
        chk("t1_empty", {31'b0, available}, 32'h0);

        // Rise 10 cycles after start, fall 5 cycles later
        sig_in = 1'b0;
        repeat (3) cyc();
        enable = 1'b1;
        cyc();
        repeat (7) cyc();
        sig_in = 1'b1;
        repeat (5) cyc();
        sig_in = 1'b0;
        repeat (4) cyc();
        enable = 1'b0;
        cyc();
        chk("t2_w0", data_out, 32'h0000_0000);
        pulse();
        chk("t2_w1", data_out, 32'h0800_000A);
        pulse();
        chk("t2_w2", data_out, 32'h0000_0005);
        pulse();
        chk("t2_empty", {31'b0, available}, 32'h0);

        // Toggles on consecutive cycles
        enable = 1'b1;
        cyc();
        sig_in = 1'b1;
        cyc();
        sig_in = 1'b0;
        cyc();
        sig_in = 1'b1;
        cyc();
        repeat (3) cyc();
        enable = 1'b0;
        cyc();
        chk("t3_w0", data_out, 32'h0000_0000);
        pulse();
        chk("t3_w1", data_out, 32'h0800_0003);
        pulse();
        chk("t3_w2", data_out, 32'h0000_0001);
        pulse();
        chk("t3_w3", data_out, 32'h0800_0001);
        pulse();
        chk("t3_empty", {31'b0, available}, 32'h0);

        // Fill to exactly DEPTH, then pop and push together while full
        enable = 1'b1;
        cyc();
        repeat (7) toggle_edge();
        cyc();
        cyc();
        chk("full_no_ovf", {31'b0, overflow}, 32'h0);
        sig_in = ~sig_in;
        cyc();
        cyc();
        read = 1'b1;
        cyc();
        read = 1'b0;
        chk("full_pop_push_ovf", {31'b0, overflow}, 32'h0);
        cyc();
        repeat (2) toggle_edge();
        cyc();
        cyc();
        chk("full_drop_ovf", {31'b0, overflow}, 32'h1);
        enable = 1'b0;
        cyc();
        drain(n);
        chk("full_occupancy", 32'(n), 32'd8);

        // Held read pops once; read on empty FIFO is ignored
        enable = 1'b1;
        cyc();
        toggle_edge();
        toggle_edge();
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        read = 1'b1;
        repeat (5) cyc();
        read = 1'b0;
        cyc();
        drain(n);
        chk("held_read_left", 32'(n), 32'd2);
        pulse();
        chk("empty_read", {31'b0, available}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sig_in = ~sig_in;
            read = ($urandom_range(0, 2) == 0);
            if (!enable && ($urandom_range(0, 19) == 0) && (m_q.size() < DEPTH)) enable = 1'b1;
            else if (enable && ($urandom_range(0, 39) == 0)) enable = 1'b0;
            cyc();
        end

        // Mid-run reset with overflow set
        enable = 1'b0;
        read   = 1'b0;
        cyc();
        drain(n);
        enable = 1'b1;
        cyc();
        repeat (10) toggle_edge();
        cyc();
        cyc();
        chk("pre_rst_ovf", {31'b0, overflow}, 32'h1);
        rst_n  = 1'b0;
        enable = 1'b0;
        cyc();
        chk("midrst_avail", {31'b0, available}, 32'h0);
        chk("midrst_ovf", {31'b0, overflow}, 32'h0);
        chk("midrst_dout", data_out, 32'h0);
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("post_rst_avail", {31'b0, available}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/channel_capture.md
# channel_capture

Per-channel acquisition front end of the logic analyzer. Samples one asynchronous probe input, run-length encodes its edges into 32-bit event words, and buffers them in a small FIFO. It presents `data_out`/`available` and accepts one-cycle `read` pops from the UART transfer stage. One instance per channel; their buses are concatenated into the transfer stage's `data_in`/`available`/`read`.

## Interface
- `DEPTH`, 8: FIFO depth in words; power of two, ≥2.
- `CNT_WIDTH`, 27: delta-counter width; fixed at 27 by the word format.
- `i_clk` in 1: system clock; all logic on rising edge.
- `_rst` in 1: reset, synchronous, active-low.
- `sig_in` in 1: asynchronous probe input.
- `enable` in 1: capture enable, level.
- `read` in 1: pop request from transfer stage.
- `data_out` out 32: head-of-FIFO word; valid while `available`=1.
- `available` out 1: FIFO non-empty.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.

## Operation
- Synchronizer: `sig_in` → two flops → `s`; `s_prev` holds the previous `s`. An edge is `s != s_prev`.
- Word format:
  - [31:29] = 0, reserved for the channel tag.
  - [28] = MARK, 1 for a saturation marker.
  - [27] = LVL, level after the event.
  - [26:0] = DELTA.
- States:
  - IDLE: no pushes; `cnt` held.
  - RUN: capture active.
- IDLE→RUN when `enable`=1. On that cycle:
  - push start word {0, MARK=0, LVL=`s`, DELTA=0};
  - `cnt` ← 1;
  - `overflow` ← 0.
- RUN→IDLE when `enable`=0. The FIFO contents are kept and stay readable.
- In RUN, evaluated in priority order each cycle:
  1. Edge: push {MARK=0, LVL=`s`, DELTA=`cnt`}; `cnt` ← 1.
  2. No edge and `cnt` = 2^27−1: push {MARK=1, LVL=`s`, DELTA=0x7FFFFFF}; `cnt` ← 1.
  3. Otherwise: `cnt` ← `cnt`+1.
- DELTA invariant: the sum of DELTAs since the start word equals the cycles elapsed since the start word. Edges on consecutive cycles give DELTA=1.
- Pop: on every rising edge of `read` (`read`=1, previous `read`=0), if `available`, advance the head. A `read` held high pops only once. A `read` edge while empty is ignored.
- Full FIFO: the push is dropped and `overflow` ← 1. If a pop and a push occur in the same cycle while full, both succeed and no overflow is flagged.
- Pointers wrap modulo DEPTH. Occupancy counter is `$clog2(DEPTH)+1` bits.
- Reset outputs:
  - `available`=0, `overflow`=0, `data_out`=0;
  - state IDLE, FIFO empty, `cnt`=0;
  - synchronizer flops and `s_prev`=0, previous-`read`=0.
- Reset asserted mid-run empties the FIFO; no partial word survives.

## Timing
- `sig_in` change to `s`: 2 cycles. Push happens in the cycle the edge is seen. `available` rises the cycle after the push; `data_out` is valid in that same cycle.
- `data_out` is registered/RAM-read so it reflects the new head the cycle after a pop. The transfer stage latches data one cycle after its `read` pulse, so this is compatible.
- `enable` rise to start word visible: 1 cycle.
- At most one push per cycle and at most one pop per cycle.

## Configuration
- `CHANNEL_CAPTURE_GLITCH_FILTER_EN`
  - Defined: a 3-flop stability stage follows the synchronizer. `s` updates only when the last 3 synchronized samples agree, which rejects pulses shorter than 3 cycles and adds 2 cycles of latency (4 total). DELTA is measured on the filtered signal.
  - Undefined: no filter; latency 2 cycles; every synchronized edge is recorded.

## Test plan
- Reset, then `enable`=1 with `sig_in`=1 → one word 0x08000000, `available`=1 after 1 cycle, `overflow`=0.
- Enabled with `sig_in`=0; toggle to 1 after 10 cycles, back to 0 after 5 more → words 0x00000000, 0x0800000A, 0x00000005.
- `sig_in` toggles every cycle for 3 cycles → three event words with DELTA=1 and alternating LVL.
- DEPTH=8, no reads, 10 edges → 8 words kept (start + 7 edges), `overflow`=1. One `read` pulse while full plus a simultaneous edge → word accepted, occupancy stays 8.
- `read` held high 5 cycles with 3 words queued → exactly one pop; empty-FIFO `read` pulse → no change; mid-run `_rst`=0 → `available`=0, `overflow`=0 next cycle.
- Filter macro defined: 2-cycle pulse on `sig_in` → no event word. 3-cycle pulse → two words.
